// File: rtl/apb_pkg.sv
// Shared types for the APB requester: FSM state encoding, queued command
// record, and the strobe helper. Field widths here set the bridge's datapath widths.
package apb_pkg;

    localparam int PROT_W     = 3;
    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;
    localparam int APB_STRB_W = APB_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
        logic [APB_STRB_W-1:0] strb;
        logic [PROT_W-1:0]     prot;
    } apb_cmd_t;

    // Reads must present all-zero strobes on the bus.
    function automatic logic [APB_STRB_W-1:0] apb_strb(input apb_cmd_t cmd);
        return cmd.write ? cmd.strb : '0;
    endfunction

endpackage

// File: rtl/apb_cmd_fifo.sv
// Command queue for the APB requester. Pointers carry one extra wrap bit so
// full and empty are distinguishable without a separate occupancy counter.
module apb_cmd_fifo
    import apb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     pclk,
    input  logic     presetn,
    input  logic     push,
    input  apb_cmd_t push_data,
    input  logic     pop,
    output apb_cmd_t pop_data,
    output logic     full,
    output logic     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = 1;

    apb_cmd_t         mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    // A push while full is dropped even if a pop frees a slot this cycle.
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge pclk) begin
        if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/apb_master_bridge.sv
// APB requester: queues valid/ready commands and runs SETUP/ACCESS per command,
// returning one response each. Optional ACCESS timeout under APB_TIMEOUT_EN.
//   state  | meaning
//   IDLE   | bus idle, waiting for a queued command
//   SETUP  | pselx=1, penable=0, exactly one cycle
//   ACCESS | pselx=1, penable=1, waiting for pready (or timeout)
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_W      = APB_ADDR_W,
    parameter int DATA_W      = APB_DATA_W,
    parameter int CMD_DEPTH   = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                pclk,
    input  logic                presetn,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_strb,
    input  logic [PROT_W-1:0]   cmd_prot,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic [ADDR_W-1:0]   paddr,
    output logic [PROT_W-1:0]   pprot,
    output logic                pselx,
    output logic                penable,
    output logic                pwrite,
    output logic [DATA_W-1:0]   pwdata,
    output logic [DATA_W/8-1:0] pstrb,
    input  logic                pready,
    input  logic [DATA_W-1:0]   prdata,
    input  logic                pslverr
);

    apb_state_e state;
    apb_cmd_t   fifo_in;
    apb_cmd_t   fifo_out;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_pop;
    logic       done;
    logic       abort;

    assign fifo_in = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata,
                       strb: cmd_strb, prot: cmd_prot};
    assign cmd_ready = !fifo_full;

    apb_cmd_fifo #(
        .DEPTH(CMD_DEPTH)
    ) u_cmd_fifo (
        .pclk      (pclk),
        .presetn   (presetn),
        .push      (cmd_valid),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .pop_data  (fifo_out),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifdef APB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    logic [TMO_W-1:0] tmo_cnt;

    // Loaded in SETUP so it reaches zero on the last allowed ACCESS cycle.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            tmo_cnt <= '0;
        end else if (state == SETUP) begin
            tmo_cnt <= TMO_LAST;
        end else if (state == ACCESS && tmo_cnt != '0) begin
            tmo_cnt <= tmo_cnt - TMO_ONE;
        end
    end

    assign abort = (state == ACCESS) && !pready && (tmo_cnt == '0);
`else
    assign abort = 1'b0;
`endif

    assign done     = (state == ACCESS) && pready;
    assign fifo_pop = !fifo_empty && ((state == IDLE) || done);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state     <= IDLE;
            paddr     <= '0;
            pprot     <= '0;
            pselx     <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
            pstrb     <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            if (fifo_pop) begin
                paddr   <= fifo_out.addr;
                pprot   <= fifo_out.prot;
                pwrite  <= fifo_out.write;
                pwdata  <= fifo_out.wdata;
                pstrb   <= apb_strb(fifo_out);
                pselx   <= 1'b1;
                penable <= 1'b0;
                state   <= SETUP;
            end else begin
                case (state)
                    SETUP: begin
                        penable <= 1'b1;
                        state   <= ACCESS;
                    end
                    ACCESS: begin
                        if (done || abort) begin
                            pselx   <= 1'b0;
                            penable <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
            // Abort implies pready is low, so done and abort never coincide.
            if (done || abort) begin
                rsp_valid <= 1'b1;
                rsp_err   <= abort | pslverr;
                rsp_rdata <= (done && !pwrite) ? prdata : '0;
            end
        end
    end

endmodule
